rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arb_grant.sv | 23 ++
 rtl/rom_port_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: FSM states, requester IDs and the
// word-alignment constant used by the address error check.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LD = 1'b1
    } req_id_t;

    localparam int WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/rom_arb_grant.sv
// One-hot grant between the fetch (bit 0) and load (bit 1) requesters.
// On a tie the requester named by pointer wins.
module rom_arb_grant
    import rom_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ld_valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (if_valid && ld_valid) begin
            grant = (pointer == REQ_LD) ? 2'b10 : 2'b01;
        end else if (if_valid) begin
            grant = 2'b01;
        end else if (ld_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one asynchronous ROM read port between fetch and load requesters,
// one request in flight. Define ROM_ARB_FAIR_EN for round-robin arbitration;
// otherwise fetch has fixed priority.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROM_BYTES  = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [DATA_WIDTH-1:0] if_addr,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    output logic                  if_rsp_valid,
    input  logic                  if_rsp_ready,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    output logic                  if_rsp_err,
    output logic                  ld_rsp_valid,
    input  logic                  ld_rsp_ready,
    output logic [DATA_WIDTH-1:0] ld_rsp_data,
    output logic                  ld_rsp_err,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    state_t                state_reg, state_next;
    req_id_t               owner_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  rsp_err_reg;

    logic [1:0]            grant;
    logic                  pointer;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic                  rsp_ready_sel;

    // Misaligned or running past the last ROM byte; the extra bit stops wrap.
    function automatic logic addr_err(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] last_byte;
        last_byte = {1'b0, a} + (DATA_WIDTH+1)'(3);
        return (a[WORD_ALIGN_BITS-1:0] != '0) ||
               (last_byte >= (DATA_WIDTH+1)'(ROM_BYTES));
    endfunction

    rom_arb_grant u_grant (
        .if_valid (if_req_valid),
        .ld_valid (ld_req_valid),
        .pointer  (pointer),
        .grant    (grant)
    );

    // Ready is masked by rst_n so nothing looks acceptable during reset.
    assign if_req_ready = rst_n && (state_reg == IDLE) && grant[0];
    assign ld_req_ready = rst_n && (state_reg == IDLE) && grant[1];
    assign accept       = if_req_ready || ld_req_ready;
    assign sel_addr     = grant[1] ? ld_addr : if_addr;

`ifdef ROM_ARB_FAIR_EN
    logic pointer_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer_reg <= REQ_IF;
        end else if (accept) begin
            pointer_reg <= grant[1] ? REQ_IF : REQ_LD;
        end
    end

    assign pointer = pointer_reg;
`else
    assign pointer = REQ_IF;
`endif

    assign rsp_ready_sel = (owner_reg == REQ_LD) ? ld_rsp_ready : if_rsp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = RESP;
            RESP:    if (rsp_ready_sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= REQ_IF;
            addr_reg     <= '0;
            err_reg      <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg <= grant[1] ? REQ_LD : REQ_IF;
                addr_reg  <= sel_addr;
                err_reg   <= addr_err(sel_addr);
            end
            if (state_reg == READ) begin
                rsp_data_reg <= err_reg ? '0 : rom_rdata;
                rsp_err_reg  <= err_reg;
            end
        end
    end

    assign rom_addr     = ((state_reg == READ) && !err_reg) ? addr_reg : '0;
    assign if_rsp_valid = (state_reg == RESP) && (owner_reg == REQ_IF);
    assign ld_rsp_valid = (state_reg == RESP) && (owner_reg == REQ_LD);
    assign if_rsp_data  = rsp_data_reg;
    assign ld_rsp_data  = rsp_data_reg;
    assign if_rsp_err   = rsp_err_reg;
    assign ld_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter against a transaction-level model
// of arbitration, latency and the address error rule.
module tb_rom_port_arbiter;

    localparam int DW = 32;
    localparam int RB = 31;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req_valid = 1'b0, ld_req_valid = 1'b0;
    logic          if_req_ready, ld_req_ready;
    logic [DW-1:0] if_addr = '0, ld_addr = '0;
    logic          if_rsp_valid, ld_rsp_valid;
    logic          if_rsp_ready = 1'b0, ld_rsp_ready = 1'b0;
    logic [DW-1:0] if_rsp_data, ld_rsp_data;
    logic          if_rsp_err, ld_rsp_err;
    logic [DW-1:0] rom_addr, rom_rdata;

    logic [7:0]    rom_mem [0:RB-1];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic          last_granted_ld = 1'b1;   // reset state: fetch wins the next tie

    always #5 clk = ~clk;

    rom_port_arbiter #(.DATA_WIDTH(DW), .ROM_BYTES(RB)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_addr(ld_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
        .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata)
    );

    function automatic logic [7:0] rom_byte(input longint a);
        return (a < RB) ? rom_mem[a] : 8'h00;
    endfunction

    always_comb begin
        rom_rdata = {rom_byte(rom_addr), rom_byte(rom_addr + 1),
                     rom_byte(rom_addr + 2), rom_byte(rom_addr + 3)};
    end

    function automatic logic ref_err(input logic [DW-1:0] a);
        longint s;
        s = a;
        return ((s % 4) != 0) || (s + 3 >= RB);
    endfunction

    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] a);
        longint s;
        s = a;
        if (ref_err(a)) return '0;
        return {rom_mem[s], rom_mem[s+1], rom_mem[s+2], rom_mem[s+3]};
    endfunction

    function automatic logic model_winner_ld(input logic ifv, input logic ldv);
        if (ifv && ldv) begin
`ifdef ROM_ARB_FAIR_EN
            return !last_granted_ld;
`else
            return 1'b0;
`endif
        end
        return ldv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Valids already driven; checks the grant and lets the accept edge pass.
    task automatic start_txn(input string name, output logic won_ld);
        #1;
        won_ld = model_winner_ld(if_req_valid, ld_req_valid);
        n_cmp++;
        if (if_req_ready !== !won_ld || ld_req_ready !== won_ld) begin
            n_fail++;
            $display("FAIL %s grant: if_ready=%b ld_ready=%b required if_ready=%b ld_ready=%b",
                     name, if_req_ready, ld_req_ready, !won_ld, won_ld);
        end
        $display("txn %s accept %s", name, won_ld ? "LD" : "IF");
        last_granted_ld = won_ld;
        tick();
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
    endtask

    // Runs from the READ cycle to the return to IDLE, holding rsp_ready low.
    task automatic finish_txn(input string name, input logic is_ld,
                              input logic [DW-1:0] addr, input int hold,
                              input logic keep_ld_valid);
        logic          exp_err;
        logic [DW-1:0] exp_data, exp_rom;
        exp_err  = ref_err(addr);
        exp_data = ref_word(addr);
        exp_rom  = exp_err ? '0 : addr;
        ld_req_valid = keep_ld_valid;
        #1;
        n_cmp++;
        if (rom_addr !== exp_rom || if_req_ready !== 1'b0 || ld_req_ready !== 1'b0 ||
            if_rsp_valid !== 1'b0 || ld_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read: rom_addr=%h rdy=%b%b vld=%b%b required rom_addr=%h rdy=00 vld=00",
                     name, rom_addr, if_req_ready, ld_req_ready, if_rsp_valid, ld_rsp_valid, exp_rom);
        end
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (is_ld) if_rsp_ready = 1'($urandom); else ld_rsp_ready = 1'($urandom);
            if (i == hold) begin
                if (is_ld) ld_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
            end
            #1;
            n_cmp++;
            if (if_rsp_valid !== !is_ld || ld_rsp_valid !== is_ld ||
                (is_ld ? ld_rsp_data : if_rsp_data) !== exp_data ||
                (is_ld ? ld_rsp_err : if_rsp_err) !== exp_err ||
                rom_addr !== '0 || if_req_ready !== 1'b0 || ld_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s resp[%0d]: vld=%b%b data=%h err=%b rom_addr=%h rdy=%b%b required vld=%b%b data=%h err=%b rom_addr=0 rdy=00",
                         name, i, if_rsp_valid, ld_rsp_valid,
                         is_ld ? ld_rsp_data : if_rsp_data, is_ld ? ld_rsp_err : if_rsp_err,
                         rom_addr, if_req_ready, ld_req_ready, !is_ld, is_ld, exp_data, exp_err);
            end
            tick();
        end
        if_rsp_ready = 1'b0;
        ld_rsp_ready = 1'b0;
        $display("txn %s done addr=%h data=%h err=%b hold=%0d", name, addr, exp_data, exp_err, hold);
    endtask

    task automatic single(input string name, input logic is_ld,
                          input logic [DW-1:0] addr, input int hold);
        logic won;
        if (is_ld) begin ld_req_valid = 1'b1; ld_addr = addr; end
        else       begin if_req_valid = 1'b1; if_addr = addr; end
        start_txn(name, won);
        finish_txn(name, won, won ? ld_addr : if_addr, hold, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < RB; i++) rom_mem[i] = 8'($urandom);
        rom_mem[4] = 8'h13; rom_mem[5] = 8'h00; rom_mem[6] = 8'h50; rom_mem[7] = 8'h93;
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        ld_req_valid = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (if_req_ready !== 1'b0 || ld_req_ready !== 1'b0 || if_rsp_valid !== 1'b0 ||
            ld_rsp_valid !== 1'b0 || if_rsp_data !== '0 || ld_rsp_data !== '0 ||
            if_rsp_err !== 1'b0 || ld_rsp_err !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b%b vld=%b%b data=%h err=%b%b rom_addr=%h required all zero",
                     if_req_ready, ld_req_ready, if_rsp_valid, ld_rsp_valid,
                     if_rsp_data, if_rsp_err, ld_rsp_err, rom_addr);
        end
        $display("txn reset checked");
        rst_n = 1'b1;
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        last_granted_ld = 1'b1;
    endtask

    task automatic test_arbitration();
        logic won;
        for (int i = 0; i < 6; i++) begin
            if_req_valid = 1'b1; if_addr = 32'(4 * (i % 6));
            ld_req_valid = 1'b1; ld_addr = 32'(4 * ((i + 2) % 6));
            start_txn("arb_tie", won);
            finish_txn("arb_tie", won, won ? ld_addr : if_addr, 0, 1'b0);
        end
        single("arb_ld_alone", 1'b1, 32'd20, 0);
    endtask

    task automatic test_vector();
        single("vector_if_0x4", 1'b0, 32'h4, 0);
    endtask

    task automatic test_err();
        single("err_misaligned", 1'b1, 32'h2, 1);
        single("err_past_end", 1'b1, 32'd28, 0);
        single("ok_last_word", 1'b1, 32'd24, 0);
        single("err_wrap", 1'b0, 32'hFFFF_FFFC, 0);
    endtask

    task automatic test_backpressure();
        logic won;
        if_req_valid = 1'b1; if_addr = 32'd8;
        start_txn("bp_if", won);
        ld_addr = 32'd12;
        finish_txn("bp_if", won, if_addr, 5, 1'b1);
        start_txn("bp_ld_resume", won);
        finish_txn("bp_ld_resume", won, ld_addr, 0, 1'b0);
    endtask

    task automatic test_random();
        logic won;
        for (int n = 0; n < 40; n++) begin
            if_req_valid = 1'($urandom);
            ld_req_valid = 1'($urandom);
            if (!if_req_valid && !ld_req_valid) ld_req_valid = 1'b1;
            if_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 35)) : 32'(4 * $urandom_range(0, 8));
            ld_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 35)) : 32'(4 * $urandom_range(0, 8));
            start_txn("random", won);
            finish_txn("random", won, won ? ld_addr : if_addr, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic won;
        if_req_valid = 1'b1; if_addr = 32'd16;
        start_txn("reset_mid", won);
        if_req_valid = 1'b1;
        ld_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if_req_ready !== 1'b0 || ld_req_ready !== 1'b0 || if_rsp_valid !== 1'b0 ||
            ld_rsp_valid !== 1'b0 || if_rsp_data !== '0 || if_rsp_err !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: rdy=%b%b vld=%b%b data=%h err=%b rom_addr=%h required all zero",
                     if_req_ready, ld_req_ready, if_rsp_valid, ld_rsp_valid, if_rsp_data, if_rsp_err, rom_addr);
        end
        tick();
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        rst_n = 1'b1;
        last_granted_ld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (if_rsp_valid !== 1'b0 || ld_rsp_valid !== 1'b0 || rom_addr !== '0) begin
                n_fail++;
                $display("FAIL reset_mid after_release[%0d]: vld=%b%b rom_addr=%h required vld=00 rom_addr=0",
                         i, if_rsp_valid, ld_rsp_valid, rom_addr);
            end
            tick();
        end
        $display("txn reset_mid aborted");
        single("after_reset", 1'b0, 32'h4, 0);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_vector();
        test_err();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
